// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int InstBus     = 32;
    localparam int InstAddrBus = 32;

    localparam logic [InstBus-1:0]     ZeroWord = '0;
    localparam logic [InstAddrBus-1:0] ZeroAddr = '0;

    // Decode issue decision as presented on issue_i.
    typedef enum logic {
        SingleIssue = 1'b0,
        DualIssue   = 1'b1
    } issue_e;

    // One queue entry: instruction word in the upper half, PC in the lower half.
    typedef struct packed {
        logic [InstBus-1:0]     inst;
        logic [InstAddrBus-1:0] addr;
    } entry_t;

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// DEPTH x 64 entry storage: two synchronous write ports, two async read ports.
module inst_fetch_queue_ram
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  entry_t           wdata1,
    input  logic             we2,
    input  logic [PTR_W-1:0] waddr2,
    input  entry_t           wdata2,
    input  logic [PTR_W-1:0] raddr1,
    output entry_t           rdata1,
    input  logic [PTR_W-1:0] raddr2,
    output entry_t           rdata2
);

    entry_t mem [DEPTH];

    // Write up to two entries per cycle; contents need no reset.
    always_ff @(posedge clk) begin
        if (we1) mem[waddr1] <= wdata1;
        if (we2) mem[waddr2] <= wdata2;
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between fetch and decode.
// Optional same-cycle bypass into an empty queue: define INST_FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   stall_id,
    input  logic                   push1_valid_i,
    input  logic [InstBus-1:0]     push1_inst_i,
    input  logic [InstAddrBus-1:0] push1_addr_i,
    input  logic                   push2_valid_i,
    input  logic [InstBus-1:0]     push2_inst_i,
    input  logic [InstAddrBus-1:0] push2_addr_i,
    output logic                   full_o,
    output logic                   inst1_valid_o,
    output logic [InstBus-1:0]     inst1_o,
    output logic [InstAddrBus-1:0] inst1_addr_o,
    output logic                   inst2_valid_o,
    output logic [InstBus-1:0]     inst2_o,
    output logic [InstAddrBus-1:0] inst2_addr_o,
    input  logic                   issue_i,
    output logic [PTR_W:0]         count_o
);

    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;

    entry_t     slot_a, slot_b;   // compacted push slots, slot_a oldest
    entry_t     rd1, rd2;
    logic [1:0] npush;            // accepted pushes this cycle
    logic [1:0] req;              // decode's requested pop count
    logic [1:0] store_pop;        // entries removed from storage
    logic [1:0] wr_skip;          // compacted pushes consumed by bypass instead of written
    logic [1:0] nwrite;           // entries written to storage
    logic       bypass;
    logic       we1, we2;
    entry_t     wdata1;

    assign full_o  = count_q > (PTR_W+1)'(DEPTH - 2);
    assign count_o = count_q;

    // Compact push slots and size this cycle's push/pop.
    always_comb begin
        slot_a    = push1_valid_i ? {push1_inst_i, push1_addr_i} : {push2_inst_i, push2_addr_i};
        slot_b    = {push2_inst_i, push2_addr_i};
        npush     = full_o ? 2'd0 : (2'(push1_valid_i) + 2'(push2_valid_i));
        req       = (issue_e'(issue_i) == DualIssue) ? 2'd2 : 2'd1;
        bypass    = 1'b0;
        store_pop = '0;
        wr_skip   = '0;
        if (!stall_id) begin
            if (count_q >= (PTR_W+1)'(req)) store_pop = req;
            else                            store_pop = count_q[1:0];
        end
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        bypass = (count_q == '0) && !flush;
        // Empty queue: decode pops straight from the push slots; only the remainder is stored.
        if (bypass) begin
            store_pop = '0;
            if (!stall_id) wr_skip = (npush >= req) ? req : npush;
        end
`endif
        nwrite = npush - wr_skip;
        we1    = !flush && (nwrite != 2'd0);
        we2    = !flush && (nwrite == 2'd2);
        wdata1 = (wr_skip == 2'd0) ? slot_a : slot_b;
    end

    inst_fetch_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we1    (we1),
        .waddr1 (tail_q),
        .wdata1 (wdata1),
        .we2    (we2),
        .waddr2 (tail_q + PTR_W'(1)),
        .wdata2 (slot_b),
        .raddr1 (head_q),
        .rdata1 (rd1),
        .raddr2 (head_q + PTR_W'(1)),
        .rdata2 (rd2)
    );

    // Head, tail and occupancy; flush overrides push and pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(store_pop);
            tail_q  <= tail_q + PTR_W'(nwrite);
            count_q <= count_q + (PTR_W+1)'(nwrite) - (PTR_W+1)'(store_pop);
        end
    end

    // Present the two oldest entries (or bypassed push slots), zeroed when invalid.
    always_comb begin
        entry_t o1, o2;
        logic   v1, v2;
        v1 = count_q != '0;
        v2 = count_q >= (PTR_W+1)'(2);
        o1 = rd1;
        o2 = rd2;
        if (bypass) begin
            v1 = npush >= 2'd1;
            v2 = npush == 2'd2;
            o1 = slot_a;
            o2 = slot_b;
        end
        inst1_valid_o = v1;
        inst1_o       = v1 ? o1.inst : ZeroWord;
        inst1_addr_o  = v1 ? o1.addr : ZeroAddr;
        inst2_valid_o = v2;
        inst2_o       = v2 ? o2.inst : ZeroWord;
        inst2_addr_o  = v2 ? o2.addr : ZeroAddr;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0, stall_id = 1'b1, issue_i = 1'b0;
    logic        push1_valid_i = 1'b0, push2_valid_i = 1'b0;
    logic [31:0] push1_inst_i = '0, push1_addr_i = '0, push2_inst_i = '0, push2_addr_i = '0;
    logic        full_o, inst1_valid_o, inst2_valid_o;
    logic [31:0] inst1_o, inst1_addr_o, inst2_o, inst2_addr_o;
    logic [PTR_W:0] count_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] mq[$];          // model contents, {inst, addr}, oldest first
    logic [31:0] pc_gen = 32'h0040_0000;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall_id(stall_id),
        .push1_valid_i(push1_valid_i), .push1_inst_i(push1_inst_i), .push1_addr_i(push1_addr_i),
        .push2_valid_i(push2_valid_i), .push2_inst_i(push2_inst_i), .push2_addr_i(push2_addr_i),
        .full_o(full_o),
        .inst1_valid_o(inst1_valid_o), .inst1_o(inst1_o), .inst1_addr_o(inst1_addr_o),
        .inst2_valid_o(inst2_valid_o), .inst2_o(inst2_o), .inst2_addr_o(inst2_addr_o),
        .issue_i(issue_i), .count_o(count_o)
    );

    task automatic set_in(input logic fl, input logic st, input logic iss,
                          input logic v1, input logic [31:0] i1, input logic [31:0] a1,
                          input logic v2, input logic [31:0] i2, input logic [31:0] a2);
        flush = fl; stall_id = st; issue_i = iss;
        push1_valid_i = v1; push1_inst_i = i1; push1_addr_i = a1;
        push2_valid_i = v2; push2_inst_i = i2; push2_addr_i = a2;
    endtask

    // Push n (0..2) fresh sequential-PC instructions with the given pop controls.
    task automatic set_push(input int n, input logic st, input logic iss);
        logic [31:0] pa, pb;
        pa = pc_gen; pb = pc_gen + 32'd4;
        set_in(1'b0, st, iss, n >= 1, $urandom, pa, n == 2, $urandom, pb);
        pc_gen = pc_gen + 32'(4 * n);
    endtask

    // Whether the model treats this cycle as a same-cycle bypass.
    function automatic bit model_bypass();
        bit b = 1'b0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        b = (mq.size() == 0) && !flush;
`endif
        return b;
    endfunction

    // Advance the model by the current inputs, then clock the DUT.
    task automatic tick(output int popped);
        logic [63:0] ins[$];
        int req;
        bit byp;
        popped = 0;
        byp = model_bypass();
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() <= DEPTH - 2) begin
                if (push1_valid_i) ins.push_back({push1_inst_i, push1_addr_i});
                if (push2_valid_i) ins.push_back({push2_inst_i, push2_addr_i});
            end
            req = stall_id ? 0 : (issue_i ? 2 : 1);
            if (byp) foreach (ins[k]) mq.push_back(ins[k]);
            popped = (req < mq.size()) ? req : mq.size();
            repeat (popped) void'(mq.pop_front());
            if (!byp) foreach (ins[k]) mq.push_back(ins[k]);
        end
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for the current model state and inputs.
    task automatic compute_exp(output logic ev1, output logic [31:0] ei1, output logic [31:0] ea1,
                               output logic ev2, output logic [31:0] ei2, output logic [31:0] ea2);
        logic [63:0] vis[$];
        if (model_bypass()) begin
            if (push1_valid_i) vis.push_back({push1_inst_i, push1_addr_i});
            if (push2_valid_i) vis.push_back({push2_inst_i, push2_addr_i});
        end else begin
            vis = mq;
        end
        ev1 = vis.size() >= 1;
        ev2 = vis.size() >= 2;
        ei1 = ev1 ? vis[0][63:32] : 32'h0;
        ea1 = ev1 ? vis[0][31:0]  : 32'h0;
        ei2 = ev2 ? vis[1][63:32] : 32'h0;
        ea2 = ev2 ? vis[1][31:0]  : 32'h0;
    endtask

    task automatic test_reset();
        int d;
        #3;
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if ({inst1_valid_o, inst2_valid_o, full_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {inst1_valid_o, inst2_valid_o, full_o}); end
        checks++; if (inst1_o !== 32'h0 || inst2_addr_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", inst1_o, inst2_addr_o); end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        set_push(2, 1'b1, 1'b0); tick(d);
        set_push(2, 1'b1, 1'b0); tick(d);
        set_push(1, 1'b1, 1'b0); tick(d);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (count_o !== 5'd5) begin errors++; $display("FAIL fill5_count: got %0d expected 5", count_o); end
        #2 resetn = 1'b0;
        mq.delete();
        #1;
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", count_o); end
        checks++; if ({inst1_valid_o, inst2_valid_o, full_o} !== 3'b000) begin errors++; $display("FAIL async_reset_flags: got %b expected 000", {inst1_valid_o, inst2_valid_o, full_o}); end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_dual_push();
        int d;
        set_in(0, 1, 0, 1, 32'h24010001, 32'hBFC00000, 1, 32'h24020002, 32'hBFC00004);
        tick(d);
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (inst1_o !== 32'h24010001) begin errors++; $display("FAIL dual_inst1: got %h expected 24010001", inst1_o); end
        checks++; if (inst2_addr_o !== 32'hBFC00004) begin errors++; $display("FAIL dual_addr2: got %h expected bfc00004", inst2_addr_o); end
        checks++; if ({inst1_valid_o, inst2_valid_o} !== 2'b11) begin errors++; $display("FAIL dual_valids: got %b expected 11", {inst1_valid_o, inst2_valid_o}); end
        tick(d);
        checks++; if (count_o !== 5'd0 || inst1_valid_o !== 1'b0) begin errors++; $display("FAIL dual_pop: got count %0d v1 %b expected 0 0", count_o, inst1_valid_o); end
    endtask

    task automatic test_issue_modes();
        int d;
        set_in(0, 1, 0, 1, 32'h11, 32'h1000, 1, 32'h22, 32'h1004); tick(d);
        set_in(0, 1, 0, 0, 0, 0, 1, 32'h33, 32'h1008); tick(d);
        checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL issue_fill: got %0d expected 3", count_o); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(d);
        checks++; if (count_o !== 5'd2 || inst1_addr_o !== 32'h1004) begin errors++; $display("FAIL single_pop: got %0d/%h expected 2/00001004", count_o, inst1_addr_o); end
        tick(d);
        checks++; if (inst1_o !== 32'h33 || inst1_addr_o !== 32'h1008) begin errors++; $display("FAIL slot2_only: got %h@%h expected 33@00001008", inst1_o, inst1_addr_o); end
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick(d);
        checks++; if (count_o !== 5'd0 || inst1_valid_o !== 1'b0) begin errors++; $display("FAIL dual_at_one: got %0d/%b expected 0/0", count_o, inst1_valid_o); end
        tick(d);
        checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL no_underflow: got %0d expected 0", count_o); end
    endtask

    task automatic test_full();
        int d;
        for (int i = 0; i < 7; i++) begin set_push(2, 1'b1, 1'b0); tick(d); end
        checks++; if (count_o !== 5'd14 || full_o !== 1'b0) begin errors++; $display("FAIL at14: got %0d/%b expected 14/0", count_o, full_o); end
        set_push(1, 1'b1, 1'b0); tick(d);
        checks++; if (count_o !== 5'd15 || full_o !== 1'b1) begin errors++; $display("FAIL at15: got %0d/%b expected 15/1", count_o, full_o); end
        set_push(2, 1'b1, 1'b0); tick(d);
        checks++; if (count_o !== 5'd15) begin errors++; $display("FAIL push_when_full: got %0d expected 15", count_o); end
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0); tick(d);
        checks++; if (count_o !== 5'd13 || full_o !== 1'b0) begin errors++; $display("FAIL pop_to13: got %0d/%b expected 13/0", count_o, full_o); end
        set_push(2, 1'b1, 1'b0); tick(d);
        checks++; if (count_o !== 5'd15) begin errors++; $display("FAIL push_to15: got %0d expected 15", count_o); end
        set_push(2, 1'b0, 1'b1); tick(d);
        checks++; if (count_o !== 5'd13) begin errors++; $display("FAIL pop_push_full: got %0d expected 13", count_o); end
        set_push(2, 1'b0, 1'b1); tick(d);
        checks++; if (count_o !== 5'd13) begin errors++; $display("FAIL pop_push_13: got %0d expected 13", count_o); end
        checks++; if (inst1_addr_o !== mq[0][31:0] || inst2_o !== mq[1][63:32]) begin errors++; $display("FAIL full_order: got %h/%h expected %h/%h", inst1_addr_o, inst2_o, mq[0][31:0], mq[1][63:32]); end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(d);
    endtask

    task automatic test_wrap();
        int popped;
        logic [31:0] exp_pc;
        exp_pc = pc_gen;
        for (int i = 0; i < 44; i++) begin
            if (i < 40) set_push(2, 1'b0, 1'b1);
            else        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
            #1;
            if (inst1_valid_o) begin
                checks++; if (inst1_addr_o !== exp_pc) begin errors++; $display("FAIL wrap_pc1 cyc %0d: got %h expected %h", i, inst1_addr_o, exp_pc); end
            end
            if (inst2_valid_o) begin
                checks++; if (inst2_addr_o !== exp_pc + 32'd4) begin errors++; $display("FAIL wrap_pc2 cyc %0d: got %h expected %h", i, inst2_addr_o, exp_pc + 32'd4); end
            end
            tick(popped);
            exp_pc = exp_pc + 32'(4 * popped);
            checks++; if (count_o !== (PTR_W+1)'(mq.size())) begin errors++; $display("FAIL wrap_count cyc %0d: got %0d expected %0d", i, count_o, mq.size()); end
        end
        checks++; if (exp_pc !== pc_gen || count_o !== 5'd0) begin errors++; $display("FAIL wrap_drain: got pc %h count %0d expected %h 0", exp_pc, count_o, pc_gen); end
    endtask

    task automatic test_flush();
        int d;
        for (int i = 0; i < 3; i++) begin set_push(2, 1'b1, 1'b0); tick(d); end
        checks++; if (count_o !== 5'd6) begin errors++; $display("FAIL flush_fill: got %0d expected 6", count_o); end
        set_push(2, 1'b0, 1'b1); flush = 1'b1;
        tick(d);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (count_o !== 5'd0 || {inst1_valid_o, inst2_valid_o, full_o} !== 3'b000) begin errors++; $display("FAIL flush: got %0d/%b expected 0/000", count_o, {inst1_valid_o, inst2_valid_o, full_o}); end
        checks++; if (inst1_o !== 32'h0 || inst2_addr_o !== 32'h0) begin errors++; $display("FAIL flush_data: got %h/%h expected 0/0", inst1_o, inst2_addr_o); end
    endtask

    task automatic test_bypass();
        int d;
        set_in(0, 1, 0, 1, 32'hAAAA0001, 32'h2000, 1, 32'hAAAA0002, 32'h2004);
        #1;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
        checks++; if (inst1_valid_o !== 1'b1 || inst1_o !== 32'hAAAA0001) begin errors++; $display("FAIL bypass_same_cycle: got %b/%h expected 1/aaaa0001", inst1_valid_o, inst1_o); end
`else
        checks++; if (inst1_valid_o !== 1'b0 || inst1_o !== 32'h0) begin errors++; $display("FAIL no_bypass: got %b/%h expected 0/0", inst1_valid_o, inst1_o); end
`endif
        tick(d);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (count_o !== 5'd2 || inst1_o !== 32'hAAAA0001) begin errors++; $display("FAIL bypass_stored: got %0d/%h expected 2/aaaa0001", count_o, inst1_o); end
        flush = 1'b1; tick(d); flush = 1'b0;
    endtask

    task automatic test_random();
        int d;
        logic ev1, ev2;
        logic [31:0] ei1, ea1, ei2, ea2;
        for (int i = 0; i < 400; i++) begin
            set_push($urandom_range(0, 2), $urandom_range(0, 3) == 0, $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                push1_valid_i = 1'b0;
                push2_valid_i = 1'b1;
            end
            flush = ($urandom_range(0, 29) == 0);
            #1;
            compute_exp(ev1, ei1, ea1, ev2, ei2, ea2);
            checks++; if (count_o !== (PTR_W+1)'(mq.size())) begin errors++; $display("FAIL rnd_count %0d: got %0d expected %0d", i, count_o, mq.size()); end
            checks++; if (full_o !== (mq.size() > DEPTH - 2)) begin errors++; $display("FAIL rnd_full %0d: got %b expected %b", i, full_o, mq.size() > DEPTH - 2); end
            checks++; if ({inst1_valid_o, inst1_o, inst1_addr_o} !== {ev1, ei1, ea1}) begin errors++; $display("FAIL rnd_slot1 %0d: got %b %h@%h expected %b %h@%h", i, inst1_valid_o, inst1_o, inst1_addr_o, ev1, ei1, ea1); end
            checks++; if ({inst2_valid_o, inst2_o, inst2_addr_o} !== {ev2, ei2, ea2}) begin errors++; $display("FAIL rnd_slot2 %0d: got %b %h@%h expected %b %h@%h", i, inst2_valid_o, inst2_o, inst2_addr_o, ev2, ei2, ea2); end
            tick(d);
        end
    endtask

    initial begin
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_dual_push();
        test_issue_modes();
        test_full();
        test_wrap();
        test_flush();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
